hscale_2x_interp: RTL and testbench

//  Horizontal 2x upscaler stage on the RGB pixel stream, feeding the vertical/output stages of the HDMI upscaler.
//  For each input line p0..pN-1 it emits 2N pixels: p0, avg(p0,p1), p1, avg(p1,p2), ..., pN-1, pN-1.
//  avg is the per-channel truncating mean (a+b)>>1. The last pixel is duplicated, not interpolated.

---
 rtl/hscale_2x_interp.sv | 166 ++++++++++++++++
 tb/tb_hscale_2x_interp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hscale_2x_interp.sv
// Horizontal 2x upscaler for a packed RGB pixel stream.
// Each input line p0..pN-1 becomes p0, avg(p0,p1), p1, ..., pN-1, pN-1.
// The averages are per-channel truncating means. The final pixel of each line
// is repeated rather than interpolated, and out_last marks that repeat.
// Line boundaries come from in_last, so line length is not fixed.
module hscale_2x_interp #(
  parameter int CHANNELS = 3,
  parameter int CW       = 8,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHANNELS*CW-1:0] in_pixel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHANNELS*CW-1:0] out_pixel,
  output logic                   out_last,
  output logic [CNT_W-1:0]       line_count
);

  localparam int PW = CHANNELS * CW;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_ORIG,
    S_WAIT,
    S_AVG,
    S_DUP
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    h_q, h_d;
  logic [PW-1:0]    n_q, n_d;
  logic             h_last_q, h_last_d;
  logic             n_last_q, n_last_d;
  logic             n_full_q, n_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_acc, out_acc;

  // Per-channel mean of two pixels. The sum is one bit wider than a channel,
  // so it cannot overflow; dropping bit 0 truncates toward zero.
  function automatic logic [PW-1:0] avg_pix(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b);
    logic [PW-1:0] r;
    logic [CW:0]   s;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s = {1'b0, a[c*CW +: CW]} + {1'b0, b[c*CW +: CW]};
      r[c*CW +: CW] = s[CW:1];
    end
    return r;
  endfunction

  assign in_acc     = in_valid && in_ready;
  assign out_acc    = out_valid && out_ready;
  assign line_count = cnt_q;

  // The outputs depend only on the registered state, so out_valid never
  // depends on out_ready and out_pixel/out_last stay stable while stalled.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_pixel = '0;
    case (state_q)
      S_EMPTY: in_ready = 1'b1;
      S_ORIG: begin
        out_valid = 1'b1;
        out_pixel = h_q;
        in_ready  = !h_last_q && !n_full_q;
      end
      S_WAIT:  in_ready = 1'b1;
      S_AVG: begin
        out_valid = 1'b1;
        out_pixel = avg_pix(h_q, n_q);
      end
      S_DUP: begin
        out_valid = 1'b1;
        out_pixel = h_q;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic. In ORIG, an input accept and an output accept in the
  // same cycle both take effect, so sustained streaming reaches one output per cycle.
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    n_d      = n_q;
    h_last_d = h_last_q;
    n_last_d = n_last_q;
    n_full_d = n_full_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_EMPTY: begin
        if (in_acc) begin
          h_d      = in_pixel;
          h_last_d = in_last;
          state_d  = S_ORIG;
        end
      end
      S_ORIG: begin
        if (in_acc) begin
          n_d      = in_pixel;
          n_last_d = in_last;
          n_full_d = 1'b1;
        end
        if (out_acc) begin
          if (h_last_q)                 state_d = S_DUP;
          else if (n_full_q || in_acc)  state_d = S_AVG;
          else                          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_acc) begin
          n_d      = in_pixel;
          n_last_d = in_last;
          n_full_d = 1'b1;
          state_d  = S_AVG;
        end
      end
      S_AVG: begin
        if (out_acc) begin
          h_d      = n_q;
          h_last_d = n_last_q;
          n_full_d = 1'b0;
          state_d  = S_ORIG;
        end
      end
      S_DUP: begin
        if (out_acc) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State registers. A reset discards any partial line without emitting out_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      h_q      <= '0;
      n_q      <= '0;
      h_last_q <= 1'b0;
      n_last_q <= 1'b0;
      n_full_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      n_q      <= n_d;
      h_last_q <= h_last_d;
      n_last_q <= n_last_d;
      n_full_q <= n_full_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hscale_2x_interp.sv
// Directed bench for hscale_2x_interp: hand-computed output sequences for
// streaming, extreme sums, backpressure, single-pixel lines, input gaps, reset.
module tb_hscale_2x_interp;

  localparam int CHANNELS = 3;
  localparam int CW       = 8;
  localparam int CNT_W    = 16;
  localparam int PW       = CHANNELS * CW;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_pixel;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_pixel;
  logic             out_last;
  logic [CNT_W-1:0] line_count;

  hscale_2x_interp #(.CHANNELS(CHANNELS), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_last   (out_last),
    .line_count (line_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          noin;
    logic          last;
    logic [PW-1:0] pix;
  } exp_t;

  logic [PW:0] pix_q[$];
  exp_t        exp_q[$];
  int total = 0;
  int bad   = 0;
  int gap_len  = 0;
  int gap_cnt  = 0;
  int tog      = 0;
  int idle_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [PW-1:0] px(input int c2, input int c1, input int c0);
    return {c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  function automatic logic [PW-1:0] grey(input int v);
    return {v[7:0], v[7:0], v[7:0]};
  endfunction

  task automatic add_in(input logic [PW-1:0] p, input logic last);
    pix_q.push_back({last, p});
  endtask

  task automatic add_exp(input logic [PW-1:0] p, input logic last, input logic noin);
    exp_t e;
    e.noin = noin;
    e.last = last;
    e.pix  = p;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic run(input int max_out);
    int            outs = 0;
    int            cyc = 0;
    logic          stall = 1'b0;
    logic          ph = 1'b1;
    logic [PW-1:0] hp;
    logic          hl;
    exp_t          e;
    gap_cnt  = 0;
    idle_cnt = 0;
    while ((pix_q.size() > 0 || exp_q.size() > 0) && outs < max_out && cyc < 400) begin
      cyc++;
      if (pix_q.size() > 0 && gap_cnt == 0) begin
        in_valid = 1'b1;
        {in_last, in_pixel} = pix_q[0];
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_pixel = '0;
      end
      out_ready = (tog != 0) ? ph : 1'b1;
      ph = ~ph;
      @(negedge clk);
      if (!out_valid) idle_cnt++;
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pixel", 32'(out_pixel), 32'(hp));
        chk("hold_last", 32'(out_last), 32'(hl));
      end
      stall = out_valid && !out_ready;
      hp = out_pixel;
      hl = out_last;
      if (out_valid && exp_q.size() > 0 && exp_q[0].noin)
        chk("in_ready_blocked", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_pixel", 32'(out_pixel), 32'(e.pix));
          chk("out_last", 32'(out_last), 32'(e.last));
          outs++;
        end
      end
      if (in_valid && in_ready) begin
        void'(pix_q.pop_front());
        gap_cnt = gap_len;
      end else if (!in_valid && gap_cnt > 0) begin
        gap_cnt--;
      end
      @(posedge clk);
      #1;
    end
    if (cyc >= 400) chk("timeout_pending", 32'(pix_q.size() + exp_q.size()), 32'd0);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
  endtask

  task automatic check_count(input string tag, input int want);
    @(negedge clk);
    chk(tag, 32'(line_count), 32'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_out_pixel"}, 32'(out_pixel), 32'd0);
    chk({tag, "_line_count"}, 32'(line_count), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Grey line 10,20,30
    add_in(grey(10), 1'b0); add_in(grey(20), 1'b0); add_in(grey(30), 1'b1);
    add_exp(grey(10), 1'b0, 1'b0); add_exp(grey(15), 1'b0, 1'b1);
    add_exp(grey(20), 1'b0, 1'b0); add_exp(grey(25), 1'b0, 1'b1);
    add_exp(grey(30), 1'b0, 1'b0); add_exp(grey(30), 1'b1, 1'b1);
    run(1000);
    check_count("count_grey", 1);

    // Extreme sums: truncation and no carry out of a channel
    add_in(px(1, 254, 255), 1'b0); add_in(px(2, 255, 255), 1'b1);
    add_exp(px(1, 254, 255), 1'b0, 1'b0); add_exp(px(1, 254, 255), 1'b0, 1'b1);
    add_exp(px(2, 255, 255), 1'b0, 1'b0); add_exp(px(2, 255, 255), 1'b1, 1'b1);
    run(1000);
    check_count("count_extreme", 2);

    // Backpressure with out_ready toggling 1010...
    tog = 1;
    add_in(px(0, 100, 200), 1'b0); add_in(px(10, 101, 255), 1'b0);
    add_in(px(20, 50, 0), 1'b0);   add_in(px(255, 255, 255), 1'b1);
    add_exp(px(0, 100, 200), 1'b0, 1'b0);   add_exp(px(5, 100, 227), 1'b0, 1'b1);
    add_exp(px(10, 101, 255), 1'b0, 1'b0);  add_exp(px(15, 75, 127), 1'b0, 1'b1);
    add_exp(px(20, 50, 0), 1'b0, 1'b0);     add_exp(px(137, 152, 127), 1'b0, 1'b1);
    add_exp(px(255, 255, 255), 1'b0, 1'b0); add_exp(px(255, 255, 255), 1'b1, 1'b1);
    run(1000);
    tog = 0;
    check_count("count_backpressure", 3);

    // Two back-to-back single-pixel lines
    add_in(px(7, 8, 9), 1'b1); add_in(px(1, 2, 3), 1'b1);
    add_exp(px(7, 8, 9), 1'b0, 1'b0); add_exp(px(7, 8, 9), 1'b1, 1'b1);
    add_exp(px(1, 2, 3), 1'b0, 1'b0); add_exp(px(1, 2, 3), 1'b1, 1'b1);
    run(1000);
    check_count("count_single", 5);

    // Input gaps of 3 cycles between pixels
    gap_len = 3;
    add_in(grey(100), 1'b0); add_in(grey(50), 1'b0); add_in(grey(51), 1'b1);
    add_exp(grey(100), 1'b0, 1'b0); add_exp(grey(75), 1'b0, 1'b1);
    add_exp(grey(50), 1'b0, 1'b0);  add_exp(grey(50), 1'b0, 1'b1);
    add_exp(grey(51), 1'b0, 1'b0);  add_exp(grey(51), 1'b1, 1'b1);
    run(1000);
    gap_len = 0;
    // EMPTY before p0, then three WAIT cycles for p1 and two for p2
    chk("gap_idle_cycles", 32'(idle_cnt), 32'd6);
    check_count("count_gaps", 6);

    // Reset mid-line after three outputs of a five-pixel line
    add_in(grey(0), 1'b0); add_in(grey(2), 1'b0); add_in(grey(4), 1'b0);
    add_in(grey(6), 1'b0); add_in(grey(8), 1'b1);
    add_exp(grey(0), 1'b0, 1'b0); add_exp(grey(1), 1'b0, 1'b1); add_exp(grey(2), 1'b0, 1'b0);
    run(3);
    chk("reset_line_outputs", 32'(exp_q.size()), 32'd0);
    pix_q.delete();
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midline_reset");

    // Line after reset starts cleanly
    add_in(grey(4), 1'b0); add_in(grey(6), 1'b1);
    add_exp(grey(4), 1'b0, 1'b0); add_exp(grey(5), 1'b0, 1'b1);
    add_exp(grey(6), 1'b0, 1'b0); add_exp(grey(6), 1'b1, 1'b1);
    run(1000);
    check_count("count_after_reset", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
